// File: rtl/shift_rows.sv
// -----------------------------------------------------------------------------
// shift_rows
//
// AES ShiftRows / InvShiftRows byte permutation. The permutation itself is pure
// wiring on text_in. Its result is captured into a 128-bit output register on
// every rising clock edge, so the stage has one cycle of latency and accepts a
// new state every cycle.
//
// State layout: row r is the word text[32r+31:32r]. Within a row, column 0 is
// the most-significant byte.
//
// Parameters:
//   INVERSE   0 = ShiftRows    (row r rotated left by r bytes)
//             1 = InvShiftRows (row r rotated right by r bytes)
//
// Ports:
//   clk       sole clock, rising-edge active
//   rst_n     synchronous active-low reset; clears text_out to zero
//   text_in   128-bit state to permute, sampled on every rising edge
//   text_out  128-bit permuted state, registered
// -----------------------------------------------------------------------------
module shift_rows #(
    parameter bit INVERSE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] text_in,
    output logic [127:0] text_out
);

    logic [127:0] text_d;
    logic [127:0] text_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            // A right rotation by r bytes is the same as a left rotation by
            // (4 - r) mod 4 bytes, so both modes share one rotate-left form.
            localparam int ROTL_BYTES = INVERSE ? ((4 - gi) % 4) : gi;

            logic [31:0] row_w;
            logic [63:0] row_dbl;

            assign row_w   = text_in[32*gi +: 32];
            // Doubling the word turns a rotate into a fixed 32-bit window.
            assign row_dbl = {row_w, row_w};

            assign text_d[32*gi +: 32] = row_dbl[63 - 8*ROTL_BYTES -: 32];
        end
    endgenerate

    // Reset has priority over the data capture on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            text_q <= '0;
        end else begin
            text_q <= text_d;
        end
    end

    assign text_out = text_q;

endmodule

// File: tb/tb_shift_rows.sv
// -----------------------------------------------------------------------------
// tb_shift_rows
//
// Drives a forward (INVERSE=0) and an inverse (INVERSE=1) instance from the
// same clock, reset and input. Expected values come from directed constants
// and from a byte-array reference model of the ShiftRows rule.
// -----------------------------------------------------------------------------
module tb_shift_rows;

    logic         clk;
    logic         rst_n;
    logic [127:0] text_in;
    logic [127:0] fwd_out;
    logic [127:0] inv_out;

    int n_checks;
    int n_fail;

    shift_rows #(.INVERSE(1'b0)) u_fwd (
        .clk      (clk),
        .rst_n    (rst_n),
        .text_in  (text_in),
        .text_out (fwd_out)
    );

    shift_rows #(.INVERSE(1'b1)) u_inv (
        .clk      (clk),
        .rst_n    (rst_n),
        .text_in  (text_in),
        .text_out (inv_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: out[row r][col c] = in[row r][col (c + r) mod 4] (forward)
    //            out[row r][col c] = in[row r][col (c - r) mod 4] (inverse)
    function automatic logic [127:0] ref_perm(input logic [127:0] x, input bit inv);
        logic [7:0]   b [4][4];
        logic [127:0] y;
        int           src;
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = x[32*r + 8*(3-c) +: 8];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                y[32*r + 8*(3-c) +: 8] = b[r][src];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Apply inputs, advance one rising edge, then settle before sampling.
    task automatic step(input logic rst_val, input logic [127:0] din);
        rst_n   = rst_val;
        text_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] stream [3];

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        text_in  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        #2;

        // Reset held for two edges with nonzero input.
        step(1'b0, 128'hdeadbeef_cafef00d_01234567_89abcdef);
        check("rst1_fwd", fwd_out, 128'h0);
        check("rst1_inv", inv_out, 128'h0);
        step(1'b0, 128'hffffffff_ffffffff_ffffffff_ffffffff);
        check("rst2_fwd", fwd_out, 128'h0);
        check("rst2_inv", inv_out, 128'h0);

        // Directed vectors.
        step(1'b1, 128'h11223344_11223344_11223344_11223344);
        check("uniform_fwd", fwd_out, 128'h44112233_33441122_22334411_11223344);
        check("uniform_inv", inv_out, ref_perm(text_in, 1'b1));

        step(1'b1, 128'h00010203_04050607_08090a0b_0c0d0e0f);
        check("distinct_fwd", fwd_out, 128'h03000102_06070405_090a0b08_0c0d0e0f);
        check("distinct_inv", inv_out, 128'h01020300_06070405_0b08090a_0c0d0e0f);

        step(1'b1, 128'h44112233_33441122_22334411_11223344);
        check("undo_inv", inv_out, 128'h11223344_11223344_11223344_11223344);
        check("undo_fwd", fwd_out, ref_perm(text_in, 1'b0));

        // Input change between edges must not disturb the register.
        x = fwd_out;
        text_in = rand128();
        #3;
        check("hold_fwd", fwd_out, x);
        check("hold_inv", inv_out, 128'h11223344_11223344_11223344_11223344);
        @(posedge clk);
        #1;
        check("late_fwd", fwd_out, ref_perm(text_in, 1'b0));

        // Back-to-back stream: each output lands exactly one edge later.
        for (int i = 0; i < 3; i++) stream[i] = rand128();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, stream[i]);
            check($sformatf("stream%0d_fwd", i), fwd_out, ref_perm(stream[i], 1'b0));
            check($sformatf("stream%0d_inv", i), inv_out, ref_perm(stream[i], 1'b1));
        end

        // Mid-stream reset discards the in-flight value.
        step(1'b0, rand128());
        check("midrst_fwd", fwd_out, 128'h0);
        check("midrst_inv", inv_out, 128'h0);
        x = rand128();
        step(1'b1, x);
        check("release_fwd", fwd_out, ref_perm(x, 1'b0));
        check("release_inv", inv_out, ref_perm(x, 1'b1));

        // Random sweep, including round-trip through the model.
        for (int i = 0; i < 20; i++) begin
            x = rand128();
            step(1'b1, x);
            check($sformatf("rand%0d_fwd", i), fwd_out, ref_perm(x, 1'b0));
            check($sformatf("rand%0d_inv", i), inv_out, ref_perm(x, 1'b1));
            check($sformatf("rand%0d_trip", i), ref_perm(fwd_out, 1'b1), x);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
